// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port arbiter in front of a single-port synchronous-read memory.
// Port 0 (CPU data) and port 1 (loader/DMA) share one memory port. One transaction
// issues per cycle. Grants are combinational, and read data returns one cycle later.
// Build option: define MEM_ARB_ROUND_ROBIN_EN to select round-robin arbitration.
// Without it, the block uses fixed priority to port 0, with a starvation guard
// that limits port 0 to MAX_HOLD consecutive wins over a waiting port 1.
module mem_port_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_gnt = 1 means port 1 won most recently, so port 0 wins the next contended cycle
  logic last_gnt;
  logic last_gnt_nxt;

  // Arbitration state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_gnt <= 1'b1;
    end else begin
      last_gnt <= last_gnt_nxt;
    end
  end

  // Next-state: remember whichever port was granted; hold when idle
  always_comb begin
    last_gnt_nxt = last_gnt;
    if (gnt0) begin
      last_gnt_nxt = 1'b0;
    end else if (gnt1) begin
      last_gnt_nxt = 1'b1;
    end
  end
`else
  localparam int unsigned HOLD_W   = 4;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_nxt;

  // Arbitration state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Next-state: count port-0 wins while port 1 waits; clear once port 1 is served or stops asking
  always_comb begin
    hold_cnt_nxt = hold_cnt;
    if (!req1 || gnt1) begin
      hold_cnt_nxt = '0;
    end else if (gnt0) begin
      hold_cnt_nxt = (hold_cnt == HOLD_MAX) ? HOLD_MAX : hold_cnt + HOLD_W'(1);
    end
  end
`endif

  // Output: grant decision, gated off while reset is asserted
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (resetn) begin
      if (req0 && req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        gnt0 = last_gnt;
        gnt1 = ~last_gnt;
`else
        gnt1 = (hold_cnt == HOLD_MAX);
        gnt0 = ~gnt1;
`endif
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Output: memory port mux; with no grant, port 0 fields pass through and no write occurs
  always_comb begin
    mem_addr  = addr0;
    mem_wdata = wdata0;
    mem_we    = gnt0 & we0;
    if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_we    = we1;
    end
  end

  // Read-valid tracking: a granted read returns data on the following cycle
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
    end
  end

  assign rdata0 = mem_rdata;
  assign rdata1 = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural 1-cycle-read memory.
// Expected grant sequences follow MEM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_port_arbiter;

  localparam int unsigned MAX_HOLD = 4;

  logic        clock;
  logic        resetn;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:255];

  logic [9:0] seq10;
  logic [7:0] seq8;
  logic [7:0] req1_pat;
  logic [4:0] seq5;

  mem_port_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port memory, synchronous read of the pre-write contents
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset with requests pending: everything forced quiet
    resetn = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 32'h55; addr1 = 32'h66; wdata0 = 32'h0; wdata1 = 32'h0;
    #2;
    chk1("rst_gnt0", gnt0, 1'b0);
    chk1("rst_gnt1", gnt1, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    repeat (2) cyc();
    chk1("rst_rvalid0", rvalid0, 1'b0);
    chk1("rst_rvalid1", rvalid1, 1'b0);
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    resetn = 1'b1;

    // Idle for three cycles
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("idle_gnt0", gnt0, 1'b0);
      chk1("idle_gnt1", gnt1, 1'b0);
      chk1("idle_mem_we", mem_we, 1'b0);
      chk32("idle_mem_addr", mem_addr, 32'h55);
      chk1("idle_rvalid0", rvalid0, 1'b0);
      chk1("idle_rvalid1", rvalid1, 1'b0);
      cyc();
    end

    // Port 0 writes DEADBEEF to 0x40
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'hDEADBEEF;
    #1;
    chk1("p0w_gnt0", gnt0, 1'b1);
    chk1("p0w_mem_we", mem_we, 1'b1);
    chk32("p0w_mem_addr", mem_addr, 32'h40);
    chk32("p0w_mem_wdata", mem_wdata, 32'hDEADBEEF);
    cyc();

    // Port 1 reads 0x40 alone
    req0 = 1'b0; we0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 32'h40;
    #1;
    chk1("p1r_rvalid0_after_write", rvalid0, 1'b0);
    chk1("p1r_gnt1", gnt1, 1'b1);
    chk1("p1r_gnt0", gnt0, 1'b0);
    chk1("p1r_mem_we", mem_we, 1'b0);
    chk32("p1r_mem_addr", mem_addr, 32'h40);
    cyc();
    req1 = 1'b0;
    #1;
    chk1("p1r_gnt1_drop", gnt1, 1'b0);
    chk1("p1r_rvalid1", rvalid1, 1'b1);
    chk32("p1r_rdata1", rdata1, 32'hDEADBEEF);
    chk1("p1r_rvalid0", rvalid0, 1'b0);
    cyc();
    chk1("p1r_rvalid1_once", rvalid1, 1'b0);

    // Port 0 writes 0x10, then port 1 reads it back
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'h12345678;
    #1;
    chk1("raw_mem_we_c1", mem_we, 1'b1);
    chk32("raw_mem_addr_c1", mem_addr, 32'h10);
    cyc();
    req0 = 1'b0; we0 = 1'b0; req1 = 1'b1; addr1 = 32'h10;
    #1;
    chk1("raw_mem_we_c2", mem_we, 1'b0);
    chk1("raw_gnt1", gnt1, 1'b1);
    cyc();
    req1 = 1'b0;
    #1;
    chk1("raw_rvalid1", rvalid1, 1'b1);
    chk32("raw_rdata1", rdata1, 32'h12345678);
    chk1("raw_mem_we_c3", mem_we, 1'b0);
    cyc();

    // Port 1 write alone never raises rvalid
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'hCAFEF00D;
    #1;
    chk1("p1w_mem_we", mem_we, 1'b1);
    chk32("p1w_mem_addr", mem_addr, 32'h20);
    chk32("p1w_mem_wdata", mem_wdata, 32'hCAFEF00D);
    cyc();
    req1 = 1'b0; we1 = 1'b0;
    #1;
    chk1("p1w_rvalid1", rvalid1, 1'b0);
    cyc();

    // Both ports read continuously for 10 cycles
`ifdef MEM_ARB_ROUND_ROBIN_EN
    seq10 = 10'b10_1010_1010;
`else
    seq10 = 10'b10_0001_0000;
`endif
    req0 = 1'b1; addr0 = 32'h40; req1 = 1'b1; addr1 = 32'h10;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk1($sformatf("both_gnt1_%0d", i), gnt1, seq10[i]);
      chk1($sformatf("both_gnt0_%0d", i), gnt0, ~seq10[i]);
      if (i > 0) begin
        chk1($sformatf("both_rvalid1_%0d", i), rvalid1, seq10[i-1]);
        chk1($sformatf("both_rvalid0_%0d", i), rvalid0, ~seq10[i-1]);
        if (seq10[i-1]) chk32($sformatf("both_rdata1_%0d", i), rdata1, 32'h12345678);
        else            chk32($sformatf("both_rdata0_%0d", i), rdata0, 32'hDEADBEEF);
      end
      cyc();
    end
    req0 = 1'b0; req1 = 1'b0;
    #1;
    chk1("both_tail_rvalid1", rvalid1, seq10[9]);
    chk1("both_tail_rvalid0", rvalid0, ~seq10[9]);
    cyc();

    // Port 1 drops its request for one cycle, which clears the hold count
`ifdef MEM_ARB_ROUND_ROBIN_EN
    seq8 = 8'b1010_1010;
`else
    seq8 = 8'b1000_0000;
`endif
    req1_pat = 8'b1111_1011;
    req0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req1 = req1_pat[i];
      #1;
      chk1($sformatf("drop_gnt1_%0d", i), gnt1, seq8[i]);
      chk1($sformatf("drop_gnt0_%0d", i), gnt0, ~seq8[i]);
      cyc();
    end
    req0 = 1'b0; req1 = 1'b0;
    cyc();

    // Reset asserted while a port-0 read is being granted, with hold count built up
    req0 = 1'b1; req1 = 1'b1;
    repeat (2) cyc();
    #1;
    chk1("rstmid_gnt0_before", gnt0, 1'b1);
    resetn = 1'b0;
    #1;
    chk1("rstmid_gnt0_forced", gnt0, 1'b0);
    chk1("rstmid_mem_we", mem_we, 1'b0);
    chk1("rstmid_rvalid0", rvalid0, 1'b0);
    cyc();
    req0 = 1'b0; req1 = 1'b0;
    resetn = 1'b1;
    #1;
    chk1("rstrel_rvalid0_a", rvalid0, 1'b0);
    cyc();
    chk1("rstrel_rvalid0_b", rvalid0, 1'b0);
    chk1("rstrel_rvalid1_b", rvalid1, 1'b0);

    // First arbitration after release starts from cleared state
`ifdef MEM_ARB_ROUND_ROBIN_EN
    seq5 = 5'b01010;
`else
    seq5 = 5'b10000;
`endif
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk1($sformatf("postrst_gnt1_%0d", i), gnt1, seq5[i]);
      chk1($sformatf("postrst_gnt0_%0d", i), gnt0, ~seq5[i]);
      cyc();
    end
    req0 = 1'b0; req1 = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
